wb_port_scheduler: RTL and testbench
====================================

// Module: wb_port_scheduler
// PURPOSE
//  Schedules register-file write ports in the writeback stage of the 4-lane VLIW core.
//  Each lane owns one write port. The load/long-latency return path has no port of its own.
//  It borrows a port left idle by a bubble lane; results that cannot be placed wait in a pending FIFO.
//  Sits between the lane result registers and the 4-write-port register file.
// PARAMETERS
//  NLANE      4   lanes and register-file write ports
//  REG_W      7   register address width (int + float file)
//  XLEN       32  data width
//  PEND_DEPTH 4   pending late-result FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous reset, active-high
//  stall      in   1            pipeline stall; lane inputs are treated as bubbles
//  lane_valid in   NLANE        lane i carries a result
//  lane_rd    in   NLANE*REG_W  lane i destination register
//  lane_data  in   NLANE*XLEN   lane i result
//  ld_valid   in   1            late result offered
//  ld_rd      in   REG_W        late result destination
//  ld_data    in   XLEN         late result data
//  ld_ready   out  1            late result accepted when ld_valid & ld_ready
//  wp_en      out  NLANE        register-file write enable, port i
//  wp_addr    out  NLANE*REG_W  register-file write address, port i
//  wp_data    out  NLANE*XLEN   register-file write data, port i
//  pend_stall out  1            frontend stall request: FIFO count >= PEND_DEPTH-1
// BEHAVIOUR
//  - Reset:
//    - all wp_* outputs are 0; the FIFO is emptied (pending results are discarded).
//    - ld_ready=1 and pend_stall=0 from the first cycle after reset.
//    - Reset mid-operation has the same effect.
//  - Lane write i is live when lane_valid[i] & ~stall & lane_rd[i]!=0. Writes to x0 are dropped.
//  - Duplicate rd among live lanes in one cycle: the highest lane index wins; lower lanes are disabled.
//  - Port i is free when lane i is not live, or has been disabled by a duplicate.
//  - Late write: at most one per cycle, placed on the lowest-index free port.
//    - Source is the FIFO head if the FIFO is non-empty; otherwise the accepted ld.
//  - Accepted ld that is not written directly is pushed to the FIFO.
//    - This covers an occupied FIFO and having no free port.
//    - ld_ready = (count < PEND_DEPTH), from registered count.
//    - Push and pop in the same cycle leave count unchanged.
//  - Squash (late results are older than lane results):
//    - A live lane write to rd r clears the valid bit of every FIFO entry with rd==r.
//    - It also drops an accepted ld with rd==r; the ld is consumed, not pushed, and not written.
//    - An invalid head is popped without using a port. Entries are tested in the same cycle they pop.
//  - ld_rd==0: the ld is accepted and dropped.
//  - Latency: lane inputs and late writes appear on wp_* 1 cycle later (registered outputs).
//  - FIFO full and no free port: ld_ready=0; the source holds ld_valid.
//    - The frontend is expected to honour pend_stall earlier.
//  - Count wraps via REG_W-independent pointers of log2(PEND_DEPTH)+1 bits.
// CONFIGURATION
//  WB_PERF_CNT_EN defined:
//    - Adds 32-bit outputs perf_pend_cycles (cycles with count!=0) and perf_squash (squashed late results).
//    - Both saturate at 2^32-1 and reset to 0.
//  WB_PERF_CNT_EN undefined: those ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  - vliw_pkg holds NLANE, REG_W, XLEN, and typedef wb_req_t {logic valid; logic [REG_W-1:0] rd; logic [XLEN-1:0] data;}.
//  - Sub-module wb_pend_fifo: the FIFO with per-entry valid and a rd-match invalidate vector.
//  - The top level holds duplicate resolution, free-port priority encoder, and output registers.
// TESTING
//  1. Lanes 0-3 write rd 1..4, ld idle:
//     -> next cycle wp_en=4'b1111, wp_addr={4,3,2,1}; the FIFO stays empty.
//  2. Lane 2 bubble, ld rd=9 data=0xDEAD:
//     -> next cycle wp_en[2]=1, wp_addr[2]=9, wp_data[2]=0xDEAD; no push.
//  3. All lanes live, 4 consecutive ld:
//     -> count reaches 4, ld_ready=0, pend_stall=1 at count 3.
//     -> Then a lane 1 bubble drains one entry per cycle in order.
//  4. FIFO holds rd=5; lane 0 writes rd 5 the same cycle:
//     -> the entry is squashed and never written; only lane 0's data reaches rd 5.
//  5. Lanes 0 and 3 both rd=7:
//     -> only wp_en[3] is set for rd 7; port 0 is free and is taken by the pending ld.
//  6. rst asserted with 3 pending entries:
//     -> next cycle count=0, wp_en=0, ld_ready=1; no stale writes afterwards.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared lane/register-file geometry and the write-request record for the
// VLIW writeback stage.
package vliw_pkg;

  localparam int NLANE = 4;   // lanes and register-file write ports
  localparam int REG_W = 7;   // register address width (int + float file)
  localparam int XLEN  = 32;  // data width

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  // One-hot of the lowest set bit; used to pick the lowest-index free port.
  function automatic logic [NLANE-1:0] lowest_one(input logic [NLANE-1:0] v);
    return v & (~v + NLANE'(1));
  endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending late-result FIFO. Every entry carries a valid bit that a live lane
// write to the same rd clears, so older late results never overwrite newer
// lane results. The head is reported with this cycle's squash already applied.
// Optional macro WB_PERF_CNT_EN adds kill_cnt (entries squashed this cycle).
module wb_pend_fifo
  import vliw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_req_t                    push_req,
  input  logic                       pop,
  input  logic [NLANE-1:0]           kill_en,
  input  logic [NLANE*REG_W-1:0]     kill_rd,
  output wb_req_t                    head,
  output logic [$clog2(DEPTH):0]     count
`ifdef WB_PERF_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] kill_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  wb_req_t        mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [DEPTH-1:0] hit;
  logic [AW-1:0]  offs;

  assign count = wr_ptr - rd_ptr;

  // Flag occupied, still-valid entries whose rd a live lane writes this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hit  = '0;
    offs = '0;
    for (int k = 0; k < DEPTH; k++) begin
      offs = AW'(k) - rd_ptr[AW-1:0];
      if (({1'b0, offs} < count) && mem[k].valid) begin
        for (int i = 0; i < NLANE; i++) begin
          if (kill_en[i] && (kill_rd[i*REG_W +: REG_W] == mem[k].rd)) hit[k] = 1'b1;
        end
      end
    end
  end

  // Head entry, tested against this cycle's lane writes before it may pop.
  always_comb begin
    head       = mem[rd_ptr[AW-1:0]];
    head.valid = head.valid & ~hit[rd_ptr[AW-1:0]];
  end

`ifdef WB_PERF_CNT_EN
  // Number of entries squashed this cycle.
  always_comb begin
    kill_cnt = '0;
    for (int k = 0; k < DEPTH; k++) kill_cnt = kill_cnt + ($clog2(DEPTH+1))'(hit[k]);
  end
`endif

  // Read/write pointers; one extra bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage: squash clears valid bits, push writes the tail slot.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy comes from the pointers, so stale entries are never seen.
    for (int k = 0; k < DEPTH; k++) begin
      if (hit[k]) mem[k].valid <= 1'b0;
    end
    if (push) mem[wr_ptr[AW-1:0]] <= push_req;
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Writeback port scheduler for the 4-lane VLIW core. Each lane owns one
// register-file write port; late (load/long-latency) results borrow a port
// left free by a bubble or a duplicate-rd loser, or wait in a pending FIFO.
// All write-port outputs are registered (1-cycle latency).
// Optional macro WB_PERF_CNT_EN adds perf_pend_cycles and perf_squash.
module wb_port_scheduler
  import vliw_pkg::*;
#(
  parameter int PEND_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [NLANE-1:0]       lane_valid,
  input  logic [NLANE*REG_W-1:0] lane_rd,
  input  logic [NLANE*XLEN-1:0]  lane_data,
  input  logic                   ld_valid,
  input  logic [REG_W-1:0]       ld_rd,
  input  logic [XLEN-1:0]        ld_data,
  output logic                   ld_ready,
  output logic [NLANE-1:0]       wp_en,
  output logic [NLANE*REG_W-1:0] wp_addr,
  output logic [NLANE*XLEN-1:0]  wp_data,
  output logic                   pend_stall
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]            perf_pend_cycles,
  output logic [31:0]            perf_squash
`endif
);
  localparam int CW = $clog2(PEND_DEPTH) + 1;

  logic [REG_W-1:0]       rd_a [NLANE];
  logic [NLANE-1:0]       live, win, late_sel;
  logic                   ld_fire, ld_kill, ld_keep, direct, push, pop, late_we, fifo_busy;
  logic [REG_W-1:0]       late_rd;
  logic [XLEN-1:0]        late_data;
  wb_req_t                head, push_req;
  logic [CW-1:0]          count;
  logic [NLANE-1:0]       en_d;
  logic [NLANE*REG_W-1:0] addr_d;
  logic [NLANE*XLEN-1:0]  data_d;

  assign ld_ready   = count < CW'(PEND_DEPTH);
  assign pend_stall = count >= CW'(PEND_DEPTH - 1);
  assign push_req   = '{valid: 1'b1, rd: ld_rd, data: ld_data};

`ifdef WB_PERF_CNT_EN
  logic [$clog2(PEND_DEPTH+1)-1:0] kill_cnt;
`endif

  wb_pend_fifo #(.DEPTH(PEND_DEPTH)) u_pend (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .kill_en  (live),
    .kill_rd  (lane_rd),
    .head     (head),
    .count    (count)
`ifdef WB_PERF_CNT_EN
    ,
    .kill_cnt (kill_cnt)
`endif
  );

  // Lane writes are live unless stalled, invalid, or aimed at x0.
  always_comb begin
    live = '0;
    for (int i = 0; i < NLANE; i++) begin
      rd_a[i] = lane_rd[i*REG_W +: REG_W];
      live[i] = lane_valid[i] & ~stall & (rd_a[i] != '0);
    end
  end

  // Duplicate rd resolution: a higher live lane with the same rd wins.
  always_comb begin
    win = live;
    for (int i = 0; i < NLANE; i++) begin
      for (int j = i + 1; j < NLANE; j++) begin
        if (live[j] && (rd_a[j] == rd_a[i])) win[i] = 1'b0;
      end
    end
  end

  // Late-write source selection, squash of the offered ld, push/pop control.
  always_comb begin
    ld_kill = 1'b0;
    for (int i = 0; i < NLANE; i++) begin
      if (live[i] && (rd_a[i] == ld_rd)) ld_kill = 1'b1;
    end
    ld_fire   = ld_valid & ld_ready;
    ld_keep   = ld_fire & (ld_rd != '0) & ~ld_kill;
    late_sel  = lowest_one(~win);
    fifo_busy = (count != '0);
    pop       = fifo_busy & (~head.valid | (|late_sel));
    direct    = ~fifo_busy & ld_keep & (|late_sel);
    push      = ld_keep & ~direct;
    late_we   = (fifo_busy & head.valid & (|late_sel)) | direct;
    late_rd   = fifo_busy ? head.rd   : ld_rd;
    late_data = fifo_busy ? head.data : ld_data;
  end

  // Next port contents: winning lane first, otherwise the late write if selected.
  always_comb begin
    en_d   = '0;
    addr_d = '0;
    data_d = '0;
    for (int i = 0; i < NLANE; i++) begin
      if (win[i]) begin
        en_d[i]                  = 1'b1;
        addr_d[i*REG_W +: REG_W] = rd_a[i];
        data_d[i*XLEN +: XLEN]   = lane_data[i*XLEN +: XLEN];
      end else if (late_we && late_sel[i]) begin
        en_d[i]                  = 1'b1;
        addr_d[i*REG_W +: REG_W] = late_rd;
        data_d[i*XLEN +: XLEN]   = late_data;
      end
    end
  end

  // Registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_en   <= '0;
      wp_addr <= '0;
      wp_data <= '0;
    end else begin
      wp_en   <= en_d;
      wp_addr <= addr_d;
      wp_data <= data_d;
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [32:0] squash_sum;
  assign squash_sum = {1'b0, perf_squash} + 33'(kill_cnt)
                    + 33'(ld_fire & (ld_rd != '0) & ld_kill);

  // Saturating counters: cycles with pending entries, squashed late results.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_pend_cycles <= '0;
      perf_squash      <= '0;
    end else begin
      if (fifo_busy && (perf_pend_cycles != '1)) perf_pend_cycles <= perf_pend_cycles + 32'd1;
      perf_squash <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Self-checking bench for wb_port_scheduler: reset checks, a table of
// single-cycle vectors, hand sequences for FIFO fill/drain, squash and
// mid-operation reset, then randomized traffic against a queue-based model.
module tb_wb_port_scheduler;
  import vliw_pkg::*;

  localparam int PEND_DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   stall;
  logic [NLANE-1:0]       lane_valid;
  logic [NLANE*REG_W-1:0] lane_rd;
  logic [NLANE*XLEN-1:0]  lane_data;
  logic                   ld_valid;
  logic [REG_W-1:0]       ld_rd;
  logic [XLEN-1:0]        ld_data;
  logic                   ld_ready;
  logic [NLANE-1:0]       wp_en;
  logic [NLANE*REG_W-1:0] wp_addr;
  logic [NLANE*XLEN-1:0]  wp_data;
  logic                   pend_stall;

  wb_port_scheduler #(.PEND_DEPTH(PEND_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .lane_valid (lane_valid),
    .lane_rd    (lane_rd),
    .lane_data  (lane_data),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .wp_en      (wp_en),
    .wp_addr    (wp_addr),
    .wp_data    (wp_data),
    .pend_stall (pend_stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending late results kept oldest-first in a queue.
  wb_req_t          pq[$];
  logic [NLANE-1:0] m_en;
  logic [REG_W-1:0] m_addr [NLANE];
  logic [XLEN-1:0]  m_data [NLANE];
  logic             m_ready, m_pstall;

  // Evaluate one cycle from the current inputs; returns the expected
  // pre-edge handshake and the expected post-edge port contents.
  task automatic model_predict();
    logic [REG_W-1:0] rdv [NLANE];
    logic             lv  [NLANE];
    int               port;
    logic             kill, fire, had;
    m_en = '0;
    for (int i = 0; i < NLANE; i++) begin m_addr[i] = '0; m_data[i] = '0; end
    m_ready  = pq.size() < PEND_DEPTH;
    m_pstall = pq.size() >= PEND_DEPTH - 1;
    if (rst) begin
      pq.delete();
      return;
    end
    for (int i = 0; i < NLANE; i++) begin
      rdv[i] = lane_rd[i*REG_W +: REG_W];
      lv[i]  = lane_valid[i] && !stall && (rdv[i] != 0);
    end
    for (int i = 0; i < NLANE; i++) begin
      if (lv[i]) begin
        m_en[i] = 1'b1;
        for (int j = i + 1; j < NLANE; j++) if (lv[j] && rdv[j] == rdv[i]) m_en[i] = 1'b0;
        if (m_en[i]) begin m_addr[i] = rdv[i]; m_data[i] = lane_data[i*XLEN +: XLEN]; end
      end
    end
    // any lane write to r makes older pending results for r obsolete
    foreach (pq[k]) for (int i = 0; i < NLANE; i++) if (lv[i] && pq[k].rd == rdv[i]) pq[k].valid = 1'b0;
    kill = 1'b0;
    for (int i = 0; i < NLANE; i++) if (lv[i] && rdv[i] == ld_rd) kill = 1'b1;
    port = -1;
    for (int i = NLANE - 1; i >= 0; i--) if (!m_en[i]) port = i;
    fire = ld_valid && m_ready;
    had  = pq.size() > 0;
    if (had) begin
      if (!pq[0].valid) void'(pq.pop_front());
      else if (port >= 0) begin
        m_en[port] = 1'b1; m_addr[port] = pq[0].rd; m_data[port] = pq[0].data;
        void'(pq.pop_front());
      end
    end
    if (fire && ld_rd != 0 && !kill) begin
      if (!had && port >= 0) begin
        m_en[port] = 1'b1; m_addr[port] = ld_rd; m_data[port] = ld_data;
      end else begin
        pq.push_back('{valid: 1'b1, rd: ld_rd, data: ld_data});
      end
    end
  endtask

  // Apply current inputs for one clock and compare against the model.
  task automatic step();
    model_predict();
    if (!rst) begin
      check("ld_ready", 32'(ld_ready), 32'(m_ready));
      check("pend_stall", 32'(pend_stall), 32'(m_pstall));
    end
    @(posedge clk);
    #1;
    check("wp_en", 32'(wp_en), 32'(m_en));
    for (int i = 0; i < NLANE; i++) begin
      if (m_en[i]) begin
        check($sformatf("wp_addr%0d", i), 32'(wp_addr[i*REG_W +: REG_W]), 32'(m_addr[i]));
        check($sformatf("wp_data%0d", i), wp_data[i*XLEN +: XLEN], m_data[i]);
      end
    end
  endtask

  task automatic set_lanes(input logic [NLANE-1:0] lv, input logic [NLANE*REG_W-1:0] rds);
    lane_valid = lv;
    lane_rd    = rds;
    for (int i = 0; i < NLANE; i++) lane_data[i*XLEN +: XLEN] = $urandom;
  endtask

  task automatic set_ld(input logic v, input logic [REG_W-1:0] rd, input logic [XLEN-1:0] d);
    ld_valid = v; ld_rd = rd; ld_data = d;
  endtask

  task automatic idle();
    stall = 1'b0;
    set_lanes('0, '0);
    set_ld(1'b0, '0, '0);
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic                   stall;
    logic [NLANE-1:0]       lv;
    logic [NLANE*REG_W-1:0] rds;
    logic                   ldv;
    logic [REG_W-1:0]       ldrd;
    logic [XLEN-1:0]        ldd;
    logic [NLANE-1:0]       exp_en;
    logic [NLANE*REG_W-1:0] exp_addr;
    int                     late;
  } vec_t;

  localparam int NV = 7;
  vec_t tv [NV];

  logic [NLANE*REG_W-1:0] amask;
  logic [XLEN-1:0]        data0;

  initial begin
    tv[0] = '{1'b0, 4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, 1'b0, 7'd0, 32'h0,
              4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, -1};
    tv[1] = '{1'b0, 4'b1011, {7'd4, 7'd0, 7'd2, 7'd1}, 1'b1, 7'd9, 32'hDEAD,
              4'b1111, {7'd4, 7'd9, 7'd2, 7'd1}, 2};
    tv[2] = '{1'b0, 4'b1111, {7'd7, 7'd2, 7'd1, 7'd7}, 1'b1, 7'd8, 32'h1234_5678,
              4'b1111, {7'd7, 7'd2, 7'd1, 7'd8}, 0};
    tv[3] = '{1'b0, 4'b1111, {7'd3, 7'd2, 7'd1, 7'd0}, 1'b0, 7'd0, 32'h0,
              4'b1110, {7'd3, 7'd2, 7'd1, 7'd0}, -1};
    tv[4] = '{1'b1, 4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, 1'b1, 7'd5, 32'hCAFE_F00D,
              4'b0001, {7'd0, 7'd0, 7'd0, 7'd5}, 0};
    tv[5] = '{1'b0, 4'b0000, {7'd0, 7'd0, 7'd0, 7'd0}, 1'b1, 7'd0, 32'hBAD0_0000,
              4'b0000, {7'd0, 7'd0, 7'd0, 7'd0}, -1};
    tv[6] = '{1'b0, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd6}, 1'b1, 7'd6, 32'h0BAD_0006,
              4'b0001, {7'd0, 7'd0, 7'd0, 7'd6}, -1};

    // reset state
    rst = 1'b1; stall = 1'b0;
    set_lanes('0, '0); set_ld(1'b0, '0, '0);
    step(); step();
    rst = 1'b0;
    check("reset_wp_en", 32'(wp_en), 32'd0);
    check("reset_ld_ready", 32'(ld_ready), 32'd1);
    check("reset_pend_stall", 32'(pend_stall), 32'd0);

    // single-cycle vectors with an empty FIFO
    for (int v = 0; v < NV; v++) begin
      stall = tv[v].stall;
      set_lanes(tv[v].lv, tv[v].rds);
      set_ld(tv[v].ldv, tv[v].ldrd, tv[v].ldd);
      step();
      for (int i = 0; i < NLANE; i++) amask[i*REG_W +: REG_W] = {REG_W{wp_en[i]}};
      check($sformatf("vec%0d_en", v), 32'(wp_en), 32'(tv[v].exp_en));
      check($sformatf("vec%0d_addr", v), 32'(wp_addr & amask), 32'(tv[v].exp_addr));
      if (tv[v].late >= 0)
        check($sformatf("vec%0d_late_data", v), wp_data[tv[v].late*XLEN +: XLEN], tv[v].ldd);
    end
    stall = 1'b0;
    idle();

    // fill the FIFO while every port is busy, then drain through lane 1 bubbles
    for (int k = 0; k < 4; k++) begin
      set_lanes(4'b1111, {7'd4, 7'd3, 7'd2, 7'd1});
      set_ld(1'b1, 7'(10 + k), $urandom);
      if (k == 3) begin
        check("fill_pstall_at3", 32'(pend_stall), 32'd1);
        check("fill_ready_at3", 32'(ld_ready), 32'd1);
      end
      step();
    end
    check("fill_ready_full", 32'(ld_ready), 32'd0);
    check("fill_pstall_full", 32'(pend_stall), 32'd1);
    set_lanes(4'b1111, {7'd4, 7'd3, 7'd2, 7'd1});
    set_ld(1'b1, 7'd14, $urandom);
    step();
    set_ld(1'b0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      set_lanes(4'b1101, {7'd4, 7'd3, 7'd2, 7'd1});
      step();
      check($sformatf("drain%0d_en1", k), 32'(wp_en[1]), 32'd1);
      check($sformatf("drain%0d_addr1", k), 32'(wp_addr[REG_W +: REG_W]), 32'(10 + k));
    end
    idle();
    check("drained_ready", 32'(ld_ready), 32'd1);

    // pending rd 5 squashed by a lane 0 write to rd 5
    set_lanes(4'b1111, {7'd4, 7'd3, 7'd2, 7'd1});
    set_ld(1'b1, 7'd5, 32'h5555_0005);
    step();
    set_ld(1'b0, '0, '0);
    set_lanes(4'b0001, {7'd0, 7'd0, 7'd0, 7'd5});
    data0 = lane_data[XLEN-1:0];
    step();
    check("squash_en", 32'(wp_en), 32'd1);
    check("squash_data", wp_data[XLEN-1:0], data0);
    idle();
    check("squash_no_stale", 32'(wp_en), 32'd0);

    // reset with three pending entries
    for (int k = 0; k < 3; k++) begin
      set_lanes(4'b1111, {7'd4, 7'd3, 7'd2, 7'd1});
      set_ld(1'b1, 7'(20 + k), $urandom);
      step();
    end
    set_lanes('0, '0); set_ld(1'b0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_wp_en", 32'(wp_en), 32'd0);
    check("midrst_ready", 32'(ld_ready), 32'd1);
    check("midrst_pstall", 32'(pend_stall), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle();
      check($sformatf("midrst_no_stale%0d", k), 32'(wp_en), 32'd0);
    end

    // randomized traffic: mixed, saturating, and light phases
    for (int c = 0; c < 900; c++) begin
      int ph;
      ph = (c / 50) % 3;
      stall = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NLANE; i++) begin
        if (ph == 1) begin
          lane_valid[i] = 1'b1;
          lane_rd[i*REG_W +: REG_W] = 7'(i + 1 + 4 * $urandom_range(0, 1));
        end else begin
          lane_valid[i] = (ph == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
          lane_rd[i*REG_W +: REG_W] = 7'($urandom_range(0, 7));
        end
        lane_data[i*XLEN +: XLEN] = $urandom;
      end
      if (!(ld_valid && !ld_ready))
        set_ld(1'($urandom_range(0, 1)), 7'($urandom_range(0, 12)), $urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
